lsu_bus_unit: RTL and testbench

- Parametrised load/store unit that replaces the direct combinational data-memory hookup of the single-cycle RV core.
- Sits between the core's execute stage (address from ALU, store data from rs2) and the data memory/MMIO bus.
- Adds byte/halfword access, sign/zero extension, misalignment and illegal-width detection, a variable-latency req/ack bus, and a timeout.
- Stalls the core until each access completes.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/lsu_align.sv | 41 ++++
 rtl/lsu_bus_unit.sv | 122 ++++++++++++
 tb/tb_lsu_bus_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RISC-V load/store width codes, LSU state encoding and lane helpers.
package cpu_pkg;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

    localparam int XLEN_DEF  = 32;
    localparam int LANE_BITS = $clog2(XLEN_DEF / 8);

    function automatic int lane_bits(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    // Doubleword and unsigned-word forms only exist on a 64-bit datapath.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3, input int xlen);
        return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W || (f3 == F3_D && xlen == 64))
                  : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU ||
                     ((f3 == F3_D || f3 == F3_WU) && xlen == 64));
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering: legality, alignment, byte enables,
// store-data shift and load extract with sign/zero extension.
module lsu_align
    import cpu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int LB   = lane_bits(XLEN)
) (
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [LB-1:0]     off,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic              legal,
    output logic              aligned,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata_sh,
    output logic [XLEN-1:0]   rdata_ext
);
    localparam int NB = XLEN / 8;

    logic [3:0]             size;
    logic [7:0]             bits;
    logic [7:0]             sa;
    logic [XLEN-1:0]        sh;
    logic signed [XLEN-1:0] sx;

    always_comb begin
        size      = 4'd1 << funct3[1:0];
        bits      = {1'b0, size, 3'b000};
        sa        = bits > 8'(XLEN) ? 8'd0 : 8'(XLEN) - bits;
        legal     = f3_legal(we, funct3, XLEN);
        aligned   = (off & LB'(size - 4'd1)) == '0;
        be        = NB'((16'd1 << size) - 16'd1) << off;
        wdata_sh  = wdata << {off, 3'b000};
        sh        = rdata >> {off, 3'b000};
        // Push the field to the top, then arithmetic-shift it back down to sign-extend.
        sx        = $signed(sh << sa) >>> sa;
        rdata_ext = funct3[2] ? (sh & ({XLEN{1'b1}} >> sa)) : sx;
    end
endmodule

// File: rtl/lsu_bus_unit.sv
// lsu_bus_unit: single-outstanding load/store unit between the core and a
// variable-latency req/ack data bus, with error detection and ack timeout.
module lsu_bus_unit
    import cpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int LB = lane_bits(XLEN);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    state_t            state, next;
    logic              we_q, err_q;
    logic [2:0]        f3_q;
    logic [LB-1:0]     off_q;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   rdata_q;
    logic              idle, go, expire, legal, aligned;
    logic [XLEN/8-1:0] be;
    logic [XLEN-1:0]   wdata_sh, ld_data;

    assign idle      = state == IDLE;
    assign go        = legal & aligned;
    assign expire    = (TIMEOUT != 0) && (int'(cnt) == TIMEOUT - 1);
    assign req_ready = idle;
    assign rsp_valid = state == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign stall     = ~rst & ((req_valid & idle) | (state == BUS));

    // Decode the live request while idle, the latched one while on the bus.
    lsu_align #(.XLEN(XLEN), .LB(LB)) u_align (
        .we        (idle ? req_we : we_q),
        .funct3    (idle ? req_funct3 : f3_q),
        .off       (idle ? req_addr[LB-1:0] : off_q),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .legal     (legal),
        .aligned   (aligned),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata_ext (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        next = idle ? (req_valid ? (go ? BUS : RESP) : IDLE)
             : state == BUS ? ((mem_ack || expire) ? RESP : BUS)
             : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else if (idle) begin
            if (req_valid) begin
                we_q      <= req_we;
                f3_q      <= req_funct3;
                off_q     <= req_addr[LB-1:0];
                cnt       <= '0;
                mem_req   <= go;
                mem_we    <= go & req_we;
                mem_addr  <= go ? {req_addr[ADDR_W-1:LB], {LB{1'b0}}} : '0;
                mem_be    <= go ? be : '0;
                mem_wdata <= go ? wdata_sh : '0;
                err_q     <= ~go;
            end
        end else if (state == BUS) begin
            // An ack on the expiry cycle still completes the access cleanly.
            if (mem_ack || expire) begin
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_be    <= '0;
                mem_wdata <= '0;
                err_q     <= ~mem_ack;
                rdata_q   <= (mem_ack && !we_q) ? ld_data : '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lsu_bus_unit.sv
// tb_lsu_bus_unit: directed and randomized accesses against an arithmetic
// model of RISC-V load/store width, alignment, lane and timeout behaviour.
module tb_lsu_bus_unit;
    import cpu_pkg::*;

    localparam int TO = 4;

    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid = 0, req_we = 0, mem_ack = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
    logic        req_ready, rsp_valid, rsp_err, stall, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    int          checks = 0, errors = 0;

    lsu_bus_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_legal(input logic we, input logic [2:0] f3);
        return we ? (f3 < 3) : (f3 < 3 || f3 == 4 || f3 == 5);
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
        int n = 8 * (1 << f3[1:0]);
        longint v;
        v = longint'(rd) >> (8 * int'(addr % 4));
        v = v % (64'sd1 << n);
        if (!f3[2] && v >= (64'sd1 << (n - 1))) v = v - (64'sd1 << n);
        return v[31:0];
    endfunction

    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata, input int ack_dly);
        int          sz, off, n;
        logic        ok;
        logic [3:0]  be;
        logic [31:0] bm, ld;
        sz  = 1 << f3[1:0];
        off = int'(addr % 4);
        ok  = exp_legal(we, f3) && (addr % sz == 0);
        be  = 4'(((1 << sz) - 1) << off);
        for (int i = 0; i < 4; i++) bm[8*i +: 8] = {8{be[i]}};
        ld  = exp_load(f3, addr, rdata);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        #1;
        check("ready_idle", req_ready, 1);
        check("stall_idle", stall, 1);
        @(posedge clk); #1;
        req_valid = 0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        #1;
        if (!ok) begin
            check("err_valid", rsp_valid, 1);
            check("err_flag", rsp_err, 1);
            check("err_rdata", rsp_rdata, 0);
            check("err_no_req", mem_req, 0);
            check("err_stall", stall, 0);
        end else begin
            n = ack_dly < TO ? ack_dly + 1 : TO;
            for (int k = 0; k < n; k++) begin
                check("bus_req", mem_req, 1);
                check("bus_we", mem_we, we);
                check("bus_addr", mem_addr, addr >> LANE_BITS << LANE_BITS);
                check("bus_be", mem_be, be);
                if (we) check("bus_wdata", mem_wdata & bm, (wdata << (8 * off)) & bm);
                check("bus_no_rsp", rsp_valid, 0);
                check("bus_stall", stall, 1);
                mem_ack = (k == ack_dly);
                mem_rdata = mem_ack ? rdata : $urandom;
                @(posedge clk); #1;
                mem_ack = 0; mem_rdata = $urandom;
                #1;
            end
            check("rsp_valid", rsp_valid, 1);
            check("rsp_req_low", mem_req, 0);
            check("rsp_stall", stall, 0);
            check("rsp_err", rsp_err, ack_dly >= TO);
            check("rsp_rdata", rsp_rdata, (we || ack_dly >= TO) ? 32'd0 : ld);
        end
        @(posedge clk); #1;
        check("rsp_pulse", rsp_valid, 0);
        check("back_idle", req_ready, 1);
    endtask

    initial begin
        #12;
        check("rst_ready", req_ready, 1);
        check("rst_req", mem_req, 0);
        check("rst_rsp", rsp_valid, 0);
        check("rst_stall", stall, 0);
        check("rst_be", mem_be, 0);
        @(posedge clk); #1 rst = 0;
        #1;
        do_access(0, F3_B,  32'h1003, 0, 32'h80AA_BBCC, 0);
        check("lb_value", exp_load(F3_B, 32'h1003, 32'h80AA_BBCC), 32'hFFFF_FF80);
        do_access(0, F3_HU, 32'h2002, 0, 32'h8001_1234, 1);
        do_access(1, F3_B,  32'h3001, 32'h0000_00A5, 0, 0);
        do_access(0, F3_W,  32'h4002, 0, 0, 0);
        do_access(0, F3_D,  32'h4000, 0, 0, 0);
        do_access(0, F3_W,  32'h0010, 0, 32'h1234_5678, 10);
        do_access(0, F3_W,  32'h0014, 0, 32'hCAFE_F00D, TO - 1);
        do_access(1, F3_H,  32'h0022, 32'hDEAD_BEEF, 0, 2);
        // Reset while the bus request is outstanding.
        req_valid = 1; req_we = 0; req_funct3 = F3_W; req_addr = 32'h40;
        @(posedge clk); #1 req_valid = 0;
        #1 check("pre_rst_req", mem_req, 1);
        #1 rst = 1;
        #1;
        check("arst_req", mem_req, 0);
        check("arst_stall", stall, 0);
        check("arst_rsp", rsp_valid, 0);
        check("arst_ready", req_ready, 1);
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;
        check("arst_no_rsp", rsp_valid, 0);
        #1;
        do_access(0, F3_W, 32'h0, 0, 32'h7654_3210, 0);
        for (int i = 0; i < 250; i++)
            do_access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 5)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
